// File: rtl/load_align_unit_pkg.sv
// -----------------------------------------------------------------------------
// types -- shared definitions for the load path.
//
// Contents:
//   rv32_memop  : memory operation encoding (load and store entries)
//   lau_state   : state encoding of the load_align_unit control FSM
//   memop_size  : access size in bytes of a load memop for a given bus width
// -----------------------------------------------------------------------------
package types;

    typedef enum logic [3:0] {
        MEMOP_BYTE   = 4'd0,
        MEMOP_HWORD  = 4'd1,
        MEMOP_WORD   = 4'd2,
        MEMOP_DWORD  = 4'd3,
        MEMOP_UBYTE  = 4'd4,
        MEMOP_UHWORD = 4'd5,
        MEMOP_UWORD  = 4'd6,
        MEMOP_SB     = 4'd7,
        MEMOP_SH     = 4'd8,
        MEMOP_SW     = 4'd9,
        MEMOP_SD     = 4'd10,
        MEMOP_NONE   = 4'd11
    } rv32_memop;

    typedef enum logic [2:0] {
        LAU_IDLE  = 3'd0,
        LAU_REQ0  = 3'd1,
        LAU_WAIT0 = 3'd2,
        LAU_REQ1  = 3'd3,
        LAU_WAIT1 = 3'd4,
        LAU_RESP  = 3'd5
    } lau_state;

    // dword only exists on a 64-bit bus, where it equals the bus width; on a
    // 32-bit bus it degrades to a full-width load like any unknown memop.
    function automatic logic [3:0] memop_size(rv32_memop op, logic [3:0] nbytes);
        case (op)
            MEMOP_BYTE,  MEMOP_UBYTE:  memop_size = 4'd1;
            MEMOP_HWORD, MEMOP_UHWORD: memop_size = 4'd2;
            MEMOP_WORD,  MEMOP_UWORD:  memop_size = 4'd4;
            default:                   memop_size = nbytes;
        endcase
    endfunction

endpackage

// File: rtl/load_align_unit_extract.sv
// -----------------------------------------------------------------------------
// load_extract -- combinational byte extraction and sign/zero extension.
//
// Ports:
//   i_hi    [DATA_W-1:0] : upper bus word (only relevant for crossing accesses)
//   i_lo    [DATA_W-1:0] : lower bus word
//   i_off   [OFF_W-1:0]  : byte offset of the access within i_lo
//   i_memop rv32_memop   : load type selecting size and extension
//   o_data  [DATA_W-1:0] : extracted and extended result
// -----------------------------------------------------------------------------
module load_extract
    import types::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]             i_hi,
    input  logic [DATA_W-1:0]             i_lo,
    input  logic [$clog2(DATA_W/8)-1:0]   i_off,
    input  rv32_memop                     i_memop,
    output logic [DATA_W-1:0]             o_data
);

    // Window of the concatenated pair starting at the addressed byte. Bytes
    // of i_hi only land in this window when the access runs past i_lo.
    logic [DATA_W-1:0] win;

    assign win = DATA_W'({i_hi, i_lo} >> {i_off, 3'b000});

    // Casting a signed slice up to DATA_W performs the sign extension.
    always_comb begin
        case (i_memop)
            MEMOP_BYTE:   o_data = DATA_W'($signed(win[7:0]));
            MEMOP_UBYTE:  o_data = DATA_W'(win[7:0]);
            MEMOP_HWORD:  o_data = DATA_W'($signed(win[15:0]));
            MEMOP_UHWORD: o_data = DATA_W'(win[15:0]);
            MEMOP_WORD:   o_data = DATA_W'($signed(win[31:0]));
            MEMOP_UWORD:  o_data = DATA_W'(win[31:0]);
            default:      o_data = win;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// -----------------------------------------------------------------------------
// load_align_unit -- handshaked load alignment between the data-memory port
// and register write-back. One request in flight; a load that crosses a bus
// word is fetched as two aligned beats and merged.
//
// Configuration macro: MISALIGNED_SPLIT_EN
//   defined   : crossing loads complete in two beats, o_rsp_fault tied 0
//   undefined : crossing loads issue no beat and respond with o_rsp_fault=1,
//               data 0; o_rsp_split tied 0
//
// Ports:
//   i_clk, i_rst                     : clock, async active-high reset
//   i_req_valid/o_req_ready          : request handshake
//   i_req_addr, i_req_memop          : byte address and load type
//   o_mem_valid/i_mem_ready          : aligned read request handshake
//   o_mem_addr                       : aligned read address
//   i_mem_rvalid, i_mem_rdata        : read data return
//   o_rsp_valid/i_rsp_ready          : response handshake
//   o_rsp_data                       : extended load result
//   o_rsp_split, o_rsp_fault         : two-beat access / crossing rejected
// -----------------------------------------------------------------------------
module load_align_unit
    import types::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [31:0]       i_req_addr,
    input  rv32_memop         i_req_memop,
    output logic              o_mem_valid,
    input  logic              i_mem_ready,
    output logic [31:0]       o_mem_addr,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_split,
    output logic              o_rsp_fault
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    lau_state          state_q, state_d;
    logic [31:0]       addr_q;
    rv32_memop         memop_q;
    logic              cross_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] hi_w;
    logic [DATA_W-1:0] ext_data;
    logic [31:0]       aligned_addr;
    logic [3:0]        req_size;
    logic [4:0]        req_end;
    logic              req_cross;
    logic              accept;

    assign req_size     = memop_size(i_req_memop, 4'(BYTES));
    assign req_end      = 5'(i_req_addr[OFF_W-1:0]) + 5'(req_size);
    assign req_cross    = req_end > 5'(BYTES);
    assign accept       = o_req_ready & i_req_valid;
    assign aligned_addr = {addr_q[31:OFF_W], {OFF_W{1'b0}}};

    // NOTE: every output and state_d is given a default before the case so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        o_req_ready = 1'b0;
        o_mem_valid = 1'b0;
        o_mem_addr  = '0;
        o_rsp_valid = 1'b0;
        case (state_q)
            LAU_IDLE: begin
                o_req_ready = ~i_rst;
                if (i_req_valid) begin
`ifdef MISALIGNED_SPLIT_EN
                    state_d = LAU_REQ0;
`else
                    state_d = req_cross ? LAU_RESP : LAU_REQ0;
`endif
                end
            end
            LAU_REQ0: begin
                o_mem_valid = 1'b1;
                o_mem_addr  = aligned_addr;
                if (i_mem_ready) state_d = LAU_WAIT0;
            end
            LAU_WAIT0: begin
`ifdef MISALIGNED_SPLIT_EN
                if (i_mem_rvalid) state_d = cross_q ? LAU_REQ1 : LAU_RESP;
`else
                if (i_mem_rvalid) state_d = LAU_RESP;
`endif
            end
`ifdef MISALIGNED_SPLIT_EN
            LAU_REQ1: begin
                o_mem_valid = 1'b1;
                o_mem_addr  = aligned_addr + 32'(BYTES);  // wraps mod 2^32
                if (i_mem_ready) state_d = LAU_WAIT1;
            end
            LAU_WAIT1: begin
                if (i_mem_rvalid) state_d = LAU_RESP;
            end
`endif
            LAU_RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) state_d = LAU_IDLE;
            end
            default: state_d = LAU_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= LAU_IDLE;
            addr_q  <= '0;
            memop_q <= MEMOP_NONE;
            cross_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= i_req_addr;
                memop_q <= i_req_memop;
                cross_q <= req_cross;
            end
        end
    end

    // NOTE: the data words carry no reset; they are only observed in RESP,
    // which is always preceded by the capture that fills them.
    always_ff @(posedge i_clk) begin
        if (state_q == LAU_WAIT0 && i_mem_rvalid) lo_q <= i_mem_rdata;
    end

`ifdef MISALIGNED_SPLIT_EN
    logic [DATA_W-1:0] hi_q;

    always_ff @(posedge i_clk) begin
        if (state_q == LAU_WAIT1 && i_mem_rvalid) hi_q <= i_mem_rdata;
    end

    assign hi_w        = hi_q;
    assign o_rsp_fault = 1'b0;
    assign o_rsp_split = (state_q == LAU_RESP) & cross_q;
`else
    // Without splitting, any crossing access that reaches RESP is a fault.
    assign hi_w        = '0;
    assign o_rsp_fault = (state_q == LAU_RESP) & cross_q;
    assign o_rsp_split = 1'b0;
`endif

    load_extract #(
        .DATA_W (DATA_W)
    ) u_extract (
        .i_hi    (hi_w),
        .i_lo    (lo_q),
        .i_off   (addr_q[OFF_W-1:0]),
        .i_memop (memop_q),
        .o_data  (ext_data)
    );

    assign o_rsp_data = (o_rsp_valid && !o_rsp_fault) ? ext_data : '0;

endmodule
